// File: rtl/core_pkg.sv
// Shared RV32I core definitions: result-select encodings, ALU operations and
// the execute-stage control bundle registered by the ID/EX pipeline register.
package core_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    alu_op_e    alu_control;
    logic       alu_src;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_BUBBLE = '0;

  // A non-instruction in decode must not carry any side effect into execute.
  function automatic ctrl_e_t gate_ctrl(input ctrl_e_t c, input logic valid);
    return valid ? c : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Enable-increment counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: one-cycle capture of operands, indices
// and control, with stall hold, flush bubbles and a saturating bubble counter.
module id_ex_reg
  import core_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic [WIDTH-1:0]      RD1D,
  input  logic [WIDTH-1:0]      RD2D,
  input  logic [WIDTH-1:0]      PCD,
  input  logic [WIDTH-1:0]      PCPlus4D,
  input  logic [WIDTH-1:0]      ImmExtD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic [3:0]            ALUControlD,
  input  logic                  ALUSrcD,
  output logic                  ValidE,
  output logic [WIDTH-1:0]      RD1E,
  output logic [WIDTH-1:0]      RD2E,
  output logic [WIDTH-1:0]      PCE,
  output logic [WIDTH-1:0]      PCPlus4E,
  output logic [WIDTH-1:0]      ImmExtE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [3:0]            ALUControlE,
  output logic                  ALUSrcE,
  output logic [CNT_W-1:0]      BubbleCount
);

  logic                  r_valid;
  logic [WIDTH-1:0]      r_rd1;
  logic [WIDTH-1:0]      r_rd2;
  logic [WIDTH-1:0]      r_pc;
  logic [WIDTH-1:0]      r_pc_plus4;
  logic [WIDTH-1:0]      r_imm;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  ctrl_e_t               r_ctrl;

  ctrl_e_t               w_ctrl_d;
  logic                  w_bubble;

  always_comb begin
    w_ctrl_d             = CTRL_BUBBLE;
    w_ctrl_d.reg_write   = RegWriteD;
    w_ctrl_d.result_src  = ResultSrcD;
    w_ctrl_d.mem_write   = MemWriteD;
    w_ctrl_d.jump        = JumpD;
    w_ctrl_d.branch      = BranchD;
    w_ctrl_d.alu_control = alu_op_e'(ALUControlD);
    w_ctrl_d.alu_src     = ALUSrcD;
  end

  // Stall wins over flush; the hazard unit re-asserts the flush after the stall.
  assign w_bubble = FlushE && !StallE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= CTRL_BUBBLE;
    end else if (!StallE) begin
      if (FlushE) begin
        // Register indices go to x0 so forwarding can never match a bubble.
        r_valid    <= 1'b0;
        r_rd1      <= '0;
        r_rd2      <= '0;
        r_pc       <= '0;
        r_pc_plus4 <= '0;
        r_imm      <= '0;
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
        r_ctrl     <= CTRL_BUBBLE;
      end else begin
        r_valid    <= ValidD;
        r_rd1      <= RD1D;
        r_rd2      <= RD2D;
        r_pc       <= PCD;
        r_pc_plus4 <= PCPlus4D;
        r_imm      <= ImmExtD;
        r_rs1      <= Rs1D;
        r_rs2      <= Rs2D;
        r_rd       <= RdD;
        r_ctrl     <= gate_ctrl(w_ctrl_d, ValidD);
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_bubble),
    .o_count (BubbleCount)
  );

  assign ValidE      = r_valid;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign PCE         = r_pc;
  assign PCPlus4E    = r_pc_plus4;
  assign ImmExtE     = r_imm;
  assign Rs1E        = r_rs1;
  assign Rs2E        = r_rs2;
  assign RdE         = r_rd;
  assign RegWriteE   = r_ctrl.reg_write;
  assign ResultSrcE  = r_ctrl.result_src;
  assign MemWriteE   = r_ctrl.mem_write;
  assign JumpE       = r_ctrl.jump;
  assign BranchE     = r_ctrl.branch;
  assign ALUControlE = r_ctrl.alu_control;
  assign ALUSrcE     = r_ctrl.alu_src;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: a 16-bit-counter instance and a 4-bit-counter instance
// share the same D-stage stimulus and are checked against one stage model.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw;
    logic [1:0]  rs;
    logic        mw, j, b;
    logic [3:0]  alu;
    logic        as;
  } stage_t;

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic        rw, mw;
    logic [31:0] x_rd2;
    logic [4:0]  x_rd;
    logic        x_rw, x_mw, x_valid;
    logic [15:0] x_cnt;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   stall = 1'b0;
  logic   flush = 1'b0;
  stage_t d_in = '0;

  always #5 clk = ~clk;

  // ---------------- DUT outputs ----------------
  logic        a_valid, b_valid;
  logic [31:0] a_rd1, a_rd2, a_pc, a_pc4, a_imm;
  logic [31:0] b_rd1, b_rd2, b_pc, b_pc4, b_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
  logic        a_rw, a_mw, a_j, a_b, a_as, b_rw, b_mw, b_j, b_b, b_as;
  logic [1:0]  a_rs, b_rs;
  logic [3:0]  a_alu, b_alu;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  wire stage_t a_e = {a_valid, a_rd1, a_rd2, a_pc, a_pc4, a_imm, a_rs1, a_rs2, a_rd,
                      a_rw, a_rs, a_mw, a_j, a_b, a_alu, a_as};
  wire stage_t b_e = {b_valid, b_rd1, b_rd2, b_pc, b_pc4, b_imm, b_rs1, b_rs2, b_rd,
                      b_rw, b_rs, b_mw, b_j, b_b, b_alu, b_as};

  id_ex_reg #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .StallE(stall), .FlushE(flush), .ValidD(d_in.valid),
    .RD1D(d_in.rd1), .RD2D(d_in.rd2), .PCD(d_in.pc), .PCPlus4D(d_in.pc4),
    .ImmExtD(d_in.imm), .Rs1D(d_in.rs1), .Rs2D(d_in.rs2), .RdD(d_in.rd),
    .RegWriteD(d_in.rw), .ResultSrcD(d_in.rs), .MemWriteD(d_in.mw), .JumpD(d_in.j),
    .BranchD(d_in.b), .ALUControlD(d_in.alu), .ALUSrcD(d_in.as),
    .ValidE(a_valid), .RD1E(a_rd1), .RD2E(a_rd2), .PCE(a_pc), .PCPlus4E(a_pc4),
    .ImmExtE(a_imm), .Rs1E(a_rs1), .Rs2E(a_rs2), .RdE(a_rd), .RegWriteE(a_rw),
    .ResultSrcE(a_rs), .MemWriteE(a_mw), .JumpE(a_j), .BranchE(a_b),
    .ALUControlE(a_alu), .ALUSrcE(a_as), .BubbleCount(a_cnt)
  );

  id_ex_reg #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .StallE(stall), .FlushE(flush), .ValidD(d_in.valid),
    .RD1D(d_in.rd1), .RD2D(d_in.rd2), .PCD(d_in.pc), .PCPlus4D(d_in.pc4),
    .ImmExtD(d_in.imm), .Rs1D(d_in.rs1), .Rs2D(d_in.rs2), .RdD(d_in.rd),
    .RegWriteD(d_in.rw), .ResultSrcD(d_in.rs), .MemWriteD(d_in.mw), .JumpD(d_in.j),
    .BranchD(d_in.b), .ALUControlD(d_in.alu), .ALUSrcD(d_in.as),
    .ValidE(b_valid), .RD1E(b_rd1), .RD2E(b_rd2), .PCE(b_pc), .PCPlus4E(b_pc4),
    .ImmExtE(b_imm), .Rs1E(b_rs1), .Rs2E(b_rs2), .RdE(b_rd), .RegWriteE(b_rw),
    .ResultSrcE(b_rs), .MemWriteE(b_mw), .JumpE(b_j), .BranchE(b_b),
    .ALUControlE(b_alu), .ALUSrcE(b_as), .BubbleCount(b_cnt)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  stage_t      exp_e = '0;
  int unsigned n_bub = 0;

  function automatic void check(input string name, input logic [191:0] act,
                                input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic int unsigned sat(input int unsigned n, input int unsigned m);
    return (n > m) ? m : n;
  endfunction

  // Reference stage: what execute should hold after the coming edge.
  task automatic tick(input string tag);
    if (!stall) begin
      if (flush) begin
        exp_e = '0;
        n_bub++;
      end else begin
        exp_e = d_in;
        if (!d_in.valid) begin
          exp_e.rw = 1'b0; exp_e.rs = 2'b0; exp_e.mw = 1'b0; exp_e.j = 1'b0;
          exp_e.b = 1'b0; exp_e.alu = 4'h0; exp_e.as = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check($sformatf("%s e16", tag), a_e, exp_e);
    check($sformatf("%s e4", tag), b_e, exp_e);
    check($sformatf("%s cnt16", tag), a_cnt, sat(n_bub, 65535));
    check($sformatf("%s cnt4", tag), b_cnt, sat(n_bub, 15));
  endtask

  // ---------------- drivers ----------------
  task automatic rand_d();
    d_in.valid = ($urandom_range(0, 9) < 8);
    d_in.rd1 = $urandom; d_in.rd2 = $urandom; d_in.pc = $urandom;
    d_in.pc4 = $urandom; d_in.imm = $urandom;
    d_in.rs1 = 5'($urandom_range(0, 31)); d_in.rs2 = 5'($urandom_range(0, 31));
    d_in.rd = 5'($urandom_range(0, 31));
    d_in.rw = 1'($urandom_range(0, 1)); d_in.rs = 2'($urandom_range(0, 2));
    d_in.mw = 1'($urandom_range(0, 1)); d_in.j = 1'($urandom_range(0, 1));
    d_in.b = 1'($urandom_range(0, 1)); d_in.alu = 4'($urandom_range(0, 10));
    d_in.as = 1'($urandom_range(0, 1));
  endtask

  // Mid-cycle asynchronous reset with every D input nonzero.
  task automatic do_reset(input string tag);
    d_in = '1;
    stall = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check($sformatf("%s async e16", tag), a_e, 192'd0);
    check($sformatf("%s async e4", tag), b_e, 192'd0);
    check($sformatf("%s async cnt16", tag), a_cnt, 192'd0);
    check($sformatf("%s async cnt4", tag), b_cnt, 192'd0);
    exp_e = '0;
    n_bub = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic v,
                              input logic [31:0] rd2, input logic [4:0] rd,
                              input logic rw, input logic mw,
                              input logic [31:0] x_rd2, input logic [4:0] x_rd,
                              input logic x_rw, input logic x_mw, input logic x_v,
                              input logic [15:0] x_cnt);
    vec_t t;
    t.stall = st; t.flush = fl; t.valid = v; t.rd2 = rd2; t.rd = rd; t.rw = rw; t.mw = mw;
    t.x_rd2 = x_rd2; t.x_rd = x_rd; t.x_rw = x_rw; t.x_mw = x_mw; t.x_valid = x_v;
    t.x_cnt = x_cnt;
    return t;
  endfunction

  vec_t vecs[11];

  initial begin
    vecs[0]  = mk(0, 0, 1, 32'hDEADBEEF, 5'd7, 1, 0, 32'hDEADBEEF, 5'd7, 1, 0, 1, 16'd0);
    vecs[1]  = mk(1, 0, 1, 32'h12345678, 5'd7, 1, 0, 32'hDEADBEEF, 5'd7, 1, 0, 1, 16'd0);
    vecs[2]  = mk(1, 0, 1, 32'h12345678, 5'd7, 1, 0, 32'hDEADBEEF, 5'd7, 1, 0, 1, 16'd0);
    vecs[3]  = mk(1, 0, 1, 32'h12345678, 5'd7, 1, 0, 32'hDEADBEEF, 5'd7, 1, 0, 1, 16'd0);
    vecs[4]  = mk(0, 0, 1, 32'h12345678, 5'd7, 1, 0, 32'h12345678, 5'd7, 1, 0, 1, 16'd0);
    vecs[5]  = mk(0, 1, 1, 32'h0000AAAA, 5'd9, 1, 1, 32'h0,        5'd0, 0, 0, 0, 16'd1);
    vecs[6]  = mk(1, 1, 1, 32'h00000033, 5'd3, 1, 1, 32'h0,        5'd0, 0, 0, 0, 16'd1);
    vecs[7]  = mk(0, 0, 0, 32'h00000055, 5'd4, 1, 1, 32'h00000055, 5'd4, 0, 0, 0, 16'd1);
    vecs[8]  = mk(0, 0, 1, 32'h00000001, 5'd2, 1, 0, 32'h00000001, 5'd2, 1, 0, 1, 16'd1);
    vecs[9]  = mk(1, 1, 1, 32'h00000077, 5'd6, 1, 1, 32'h00000001, 5'd2, 1, 0, 1, 16'd1);
    vecs[10] = mk(0, 1, 1, 32'h00000077, 5'd6, 1, 1, 32'h0,        5'd0, 0, 0, 0, 16'd2);

    // Power-on reset values.
    repeat (2) @(negedge clk);
    check("por e16", a_e, 192'd0);
    check("por cnt16", a_cnt, 192'd0);
    check("por cnt4", b_cnt, 192'd0);
    rst_n = 1'b1;

    // Randomized traffic against the stage model.
    for (int i = 0; i < 300; i++) begin
      rand_d();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 4) == 0);
      tick($sformatf("rand%0d", i));
    end

    do_reset("mid");
    tick("post_reset");

    // Directed vectors: capture, stall hold, flush, stall+flush, invalid decode.
    do_reset("tbl");
    for (int i = 0; i < 11; i++) begin
      d_in = '0;
      d_in.valid = vecs[i].valid;
      d_in.rd2 = vecs[i].rd2;
      d_in.rd = vecs[i].rd;
      d_in.rw = vecs[i].rw;
      d_in.mw = vecs[i].mw;
      stall = vecs[i].stall;
      flush = vecs[i].flush;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d RD2E", i), a_rd2, vecs[i].x_rd2);
      check($sformatf("vec%0d RdE", i), a_rd, vecs[i].x_rd);
      check($sformatf("vec%0d RegWriteE", i), a_rw, vecs[i].x_rw);
      check($sformatf("vec%0d MemWriteE", i), a_mw, vecs[i].x_mw);
      check($sformatf("vec%0d ValidE", i), a_valid, vecs[i].x_valid);
      check($sformatf("vec%0d BubbleCount", i), a_cnt, vecs[i].x_cnt);
    end

    // 17 back-to-back flushes: the 4-bit counter must stick at 15.
    do_reset("satrst");
    for (int k = 1; k <= 17; k++) begin
      rand_d();
      stall = 1'b0;
      flush = 1'b1;
      tick($sformatf("sat%0d", k));
      check($sformatf("sat%0d cnt4 const", k), b_cnt, (k < 15) ? k : 15);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register of the RV32I 5-stage core.
- Captures decode-stage operands, immediates, register indices and control fields each cycle, and presents them to the execute stage.
- Its outputs feed the execute-stage operand forwarding muxes, the hazard unit (Rs1E/Rs2E/RdE) and the ALU control.
- Supports hold on stall, bubble insertion on flush, and a saturating bubble counter for performance monitoring.

Parameters:
WIDTH, 32, datapath width of operands, PC and immediate
REG_ADDR_W, 5, register index width
CNT_W, 16, width of the bubble counter

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
StallE  input  1  hold all E-stage state (cache miss / load-use freeze)
FlushE  input  1  replace next E-stage contents with a bubble
ValidD  input  1  decode stage holds a real instruction
RD1D  input  WIDTH  register file read data 1
RD2D  input  WIDTH  register file read data 2
PCD  input  WIDTH  decode PC
PCPlus4D  input  WIDTH  decode PC+4
ImmExtD  input  WIDTH  sign-extended immediate
Rs1D  input  REG_ADDR_W  source register 1 index
Rs2D  input  REG_ADDR_W  source register 2 index
RdD  input  REG_ADDR_W  destination register index
RegWriteD  input  1  register write enable
ResultSrcD  input  2  result select (ALU/mem/PC+4)
MemWriteD  input  1  data memory write enable
JumpD  input  1  jump instruction
BranchD  input  1  branch instruction
ALUControlD  input  4  ALU operation
ALUSrcD  input  1  ALU B-operand select (reg/imm)
ValidE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE  output  (matching D widths)  registered E-stage copies
BubbleCount  output  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, including BubbleCount and ValidE. A reset pulse mid-stream discards the held instruction. The first rising edge after release captures D inputs normally.
- Latency: exactly 1 cycle, D to E.
- Priority per edge: StallE > FlushE > normal capture.
- StallE=1: every E register, including ValidE, holds its value. BubbleCount holds. A simultaneous FlushE is ignored; the hazard unit keeps FlushE asserted until the stall drops.
- FlushE=1, StallE=0:
  - RegWriteE, MemWriteE, JumpE, BranchE and ValidE are cleared.
  - RdE, Rs1E and Rs2E are cleared to x0, so downstream forwarding never matches a bubble.
  - Data fields (RD1E, RD2E, PCE, PCPlus4E, ImmExtE) are cleared to 0. ResultSrcE, ALUControlE and ALUSrcE are cleared to 0.
  - BubbleCount increments by 1.
- Normal capture (neither asserted): every E field takes the D value.
  - If ValidD=0, the captured control enables are forced to 0, identical to a flush, and ValidE=0.
  - This case does not count as a bubble.
- BubbleCount saturates at all-ones. A further flush leaves it at max with no wrap.
- No combinational path from any input to any output.

Decomposition:
- Shared package (core_pkg):
  - ResultSrc encodings: RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10.
  - ALUControl enum (4-bit).
  - A packed struct ctrl_e_t bundling RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl and ALUSrc, so control is registered and cleared as one field.
- One natural sub-module: sat_counter (CNT_W-bit, enable-increment, saturate, async active-low reset), used for BubbleCount.
- Data fields are a flat always_ff with no further sub-modules.

Test Plan:
- Reset: drive all D inputs nonzero and pulse rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge, and BubbleCount=0.
- Capture: RD2D=32'hDEADBEEF, RdD=5'd7, RegWriteD=1, ValidD=1, both controls low -> the next edge gives RD2E=32'hDEADBEEF, RdE=7, RegWriteE=1, ValidE=1.
- Stall hold: after the capture above, set StallE=1 for 3 cycles while changing RD2D to 32'h12345678 -> RD2E stays 32'hDEADBEEF for all 3 cycles, then updates to 32'h12345678 on the edge after StallE drops.
- Flush:
  - FlushE=1 with RegWriteD=1, MemWriteD=1, RdD=5'd9 -> the next edge gives RegWriteE=0, MemWriteE=0, RdE=0, ValidE=0, BubbleCount=1.
  - StallE=1 and FlushE=1 together -> state held and BubbleCount unchanged.
- Invalid decode: ValidD=0 with RegWriteD=1 -> RegWriteE=0 and ValidE=0, BubbleCount unchanged.
- Saturation (CNT_W=4): 17 consecutive flushes -> BubbleCount reads 15 after the 15th flush and stays at 15 through the 17th.
